cordic_quadrant_fold: RTL and testbench

// - Upstream range-reduction stage for the Sine CORDIC core; also post-processes the core's result.
// - Takes a full-circle binary phase, folds it into the first quadrant and scales it to Q2.14 radians.
// - Drives the core's Start/Angle inputs, waits for its Done, then applies the quadrant sign.
// - Gives a sine valid over the full 0..360 deg range; the core itself only converges within +/-pi/2.

---
 rtl/cordic_quadrant_fold_if.sv | 24 ++
 rtl/cordic_quadrant_fold.sv | 205 ++++++++++++++++++++
 tb/tb_cordic_quadrant_fold.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_quadrant_fold_if.sv
// Request/result and core-side handshake bundle for cordic_quadrant_fold.
// The slave modport is the fold stage; the master modport is its environment (requester and core).
interface cordic_quadrant_fold_if;
   logic        start;
   logic [15:0] phase;
   logic        busy;
   logic [15:0] sine;
   logic        done;
   logic        err;
   logic [15:0] core_angle;
   logic        core_start;
   logic [15:0] core_sine;
   logic        core_done;

   modport master (
      output start, phase, core_sine, core_done,
      input  busy, sine, done, err, core_angle, core_start
   );

   modport slave (
      input  start, phase, core_sine, core_done,
      output busy, sine, done, err, core_angle, core_start
   );
endinterface

// File: rtl/cordic_quadrant_fold.sv
// Quadrant fold / unfold stage around a sine CORDIC core: full-circle phase in, Q1.15 sine out.
// Optional core-latency watchdog enabled by defining QFOLD_TIMEOUT_EN.
module cordic_quadrant_fold #(
   parameter logic [15:0] K_PI_HALF = 16'h6488
`ifdef QFOLD_TIMEOUT_EN
   , parameter int unsigned TIMEOUT_CYCLES = 32'd64
`endif
) (
   input logic                     clk,
   input logic                     rst_n,
   cordic_quadrant_fold_if.slave   bus
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_MUL    = 3'd1,
      ST_LAUNCH = 3'd2,
      ST_WAIT   = 3'd3,
      ST_FIX    = 3'd4
   } state_t;

   // Quadrants 1 and 3 run backwards, so their residue is measured from the next axis.
   function automatic logic [14:0] fold_residue(input logic [15:0] ph);
      logic [14:0] r;
      r = {1'b0, ph[13:0]};
      if (ph[14]) begin
         fold_residue = 15'h4000 - r;
      end else begin
         fold_residue = r;
      end
   endfunction

   function automatic logic [15:0] scale_angle(input logic [14:0] res);
      scale_angle = 16'(({15'd0, res} * {14'd0, K_PI_HALF}) >> 14);
   endfunction

   // -(-1.0) is not representable in Q1.15, so it clamps to the largest positive value.
   function automatic logic [15:0] apply_sign(input logic neg, input logic [15:0] v);
      if (!neg) begin
         apply_sign = v;
      end else if (v == 16'h8000) begin
         apply_sign = 16'h7FFF;
      end else begin
         apply_sign = 16'h0000 - v;
      end
   endfunction

   state_t      state_r, state_s;
   logic [14:0] res_r, res_s;
   logic        neg_r, neg_s;
   logic [15:0] angle_r, angle_s;
   logic [15:0] sine_r, sine_s;
   logic        core_start_r, core_start_s;
   logic        done_r, done_s;
   logic        busy_r, busy_s;
   logic        timeout_s;

`ifdef QFOLD_TIMEOUT_EN
   logic [7:0]  cnt_r, cnt_s;
   logic        err_r, err_s;

   // Watchdog counter: cleared while launching, counts every cycle spent in WAIT.
   always_comb begin
      cnt_s = cnt_r;
      if (state_r == ST_LAUNCH) begin
         cnt_s = 8'd0;
      end else if (state_r == ST_WAIT) begin
         cnt_s = cnt_r + 8'd1;
      end else begin
         cnt_s = cnt_r;
      end
   end

   assign timeout_s = (state_r == ST_WAIT) && (cnt_r == 8'(TIMEOUT_CYCLES - 32'd1));

   // Watchdog counter and error flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= 8'd0;
         err_r <= 1'b0;
      end else begin
         cnt_r <= cnt_s;
         err_r <= err_s;
      end
   end

   assign bus.err = err_r;
`else
   assign timeout_s = 1'b0;
   assign bus.err   = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               state_s = ST_MUL;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_MUL:    state_s = ST_LAUNCH;
         ST_LAUNCH: state_s = ST_WAIT;
         ST_WAIT: begin
            if (bus.core_done || timeout_s) begin
               state_s = ST_FIX;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_FIX:    state_s = ST_IDLE;
         default:   state_s = ST_IDLE;
      endcase
   end

   // FSM output logic: next values of the registered outputs and latched operands.
   always_comb begin
      res_s        = res_r;
      neg_s        = neg_r;
      angle_s      = angle_r;
      sine_s       = sine_r;
      core_start_s = 1'b0;
      done_s       = 1'b0;
      busy_s       = (state_s != ST_IDLE);
`ifdef QFOLD_TIMEOUT_EN
      err_s        = err_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               res_s = fold_residue(bus.phase);
               neg_s = bus.phase[15];
`ifdef QFOLD_TIMEOUT_EN
               err_s = 1'b0;
`endif
            end else begin
               res_s = res_r;
            end
         end
         ST_MUL: begin
            angle_s      = scale_angle(res_r);
            core_start_s = 1'b1;
         end
         ST_WAIT: begin
            if (bus.core_done) begin
               sine_s = apply_sign(neg_r, bus.core_sine);
               done_s = 1'b1;
            end else if (timeout_s) begin
               sine_s = 16'h0000;
               done_s = 1'b1;
`ifdef QFOLD_TIMEOUT_EN
               err_s  = 1'b1;
`endif
            end else begin
               done_s = 1'b0;
            end
         end
         ST_LAUNCH, ST_FIX: begin
            core_start_s = 1'b0;
         end
         default: begin
            core_start_s = 1'b0;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_r        <= 15'd0;
         neg_r        <= 1'b0;
         angle_r      <= 16'h0000;
         sine_r       <= 16'h0000;
         core_start_r <= 1'b0;
         done_r       <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         res_r        <= res_s;
         neg_r        <= neg_s;
         angle_r      <= angle_s;
         sine_r       <= sine_s;
         core_start_r <= core_start_s;
         done_r       <= done_s;
         busy_r       <= busy_s;
      end
   end

   assign bus.busy       = busy_r;
   assign bus.sine       = sine_r;
   assign bus.done       = done_r;
   assign bus.core_angle = angle_r;
   assign bus.core_start = core_start_r;

endmodule

// File: tb/tb_cordic_quadrant_fold.sv
// Self-checking bench for cordic_quadrant_fold with a fixed-latency core model and an arithmetic reference.
module tb_cordic_quadrant_fold;

   localparam int TIMEOUT = 64;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   cordic_quadrant_fold_if bus();

   cordic_quadrant_fold dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   int          core_lat   = 3;
   logic [15:0] core_val   = 16'h0000;
   bit          core_mute  = 1'b0;
   logic        model_done = 1'b0;
   logic        stray      = 1'b0;
   int          remaining  = 0;

   assign bus.core_done = model_done | stray;
   assign bus.core_sine = core_val;

   // Core model: answers core_lat cycles after it sees its start pulse.
   always @(negedge clk) begin
      model_done = 1'b0;
      if (remaining > 0) begin
         remaining = remaining - 1;
         if (remaining == 0 && !core_mute) model_done = 1'b1;
      end
      if (bus.core_start === 1'b1) remaining = core_lat;
   end

   typedef struct packed {
      logic [15:0] sine;
      logic        err;
      logic [15:0] angle_l;
      logic [15:0] angle_w;
      int          done_cyc;
      int          done_cnt;
      int          start_cyc;
      int          start_cnt;
      int          busy_bad;
   } obs_t;

   function automatic logic [15:0] ref_angle(input logic [15:0] ph);
      int q, r, res;
      q   = int'(ph) / 16384;
      r   = int'(ph) % 16384;
      res = (q % 2 == 0) ? r : 16384 - r;
      return 16'((res * 25736) / 16384);
   endfunction

   function automatic logic [15:0] ref_sine(input logic [15:0] ph, input logic [15:0] v);
      int s;
      s = int'($signed(v));
      if (int'(ph) >= 32768) s = -s;
      if (s > 32767) s = 32767;
      return 16'(s);
   endfunction

   // Issues one request at the current negedge and observes every cycle up to one past Done.
   task automatic run_req(input logic [15:0] ph, input logic [15:0] cval, input int n,
                          input bit mute, input int poke_k, input logic [15:0] poke_ph,
                          input int stray_k, output obs_t o);
      o = '0;
      o.done_cyc  = -1;
      o.start_cyc = -1;
      core_val  = cval;
      core_lat  = n;
      core_mute = mute;
      bus.start = 1'b1;
      bus.phase = ph;
      for (int k = 1; k <= 4 + n; k++) begin
         @(negedge clk);
         bus.start = (k == poke_k);
         bus.phase = (k == poke_k) ? poke_ph : 16'($urandom);
         stray     = (k == stray_k);
         if (bus.done === 1'b1) begin
            o.done_cnt++;
            o.done_cyc = k;
            o.sine     = bus.sine;
            o.err      = bus.err;
         end
         if (bus.core_start === 1'b1) begin
            o.start_cnt++;
            o.start_cyc = k;
         end
         if (k == 2) o.angle_l = bus.core_angle;
         if (k == 2 + n) o.angle_w = bus.core_angle;
         if (bus.busy !== ((k <= 3 + n) ? 1'b1 : 1'b0)) o.busy_bad++;
      end
      bus.start = 1'b0;
      stray     = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus.done); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      n_cmp++; if (bus.sine !== 16'h0000) begin n_bad++; $display("FAIL reset_sine got %h want 0000", bus.sine); end
      n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", bus.err); end
      n_cmp++; if (bus.core_angle !== 16'h0000) begin n_bad++; $display("FAIL reset_angle got %h want 0000", bus.core_angle); end
      n_cmp++; if (bus.core_start !== 1'b0) begin n_bad++; $display("FAIL reset_cstart got %b want 0", bus.core_start); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   logic [15:0] d_ph  [8] = '{16'h1555, 16'h6AAB, 16'hEAAB, 16'h4000, 16'h8000, 16'hC000, 16'hA000, 16'h0000};
   logic [15:0] d_val [8] = '{16'h4000, 16'h4000, 16'h4000, 16'h1234, 16'h8000, 16'h0000, 16'h7FFF, 16'h2000};
   int          d_n   [8] = '{3, 2, 4, 1, 2, 3, 5, 1};
   logic [15:0] d_ang [8] = '{16'h2182, 16'h2182, 16'h2182, 16'h6488, 16'h0000, 16'h6488, 16'h3244, 16'h0000};
   logic [15:0] d_sin [8] = '{16'h4000, 16'h4000, 16'hC000, 16'h1234, 16'h7FFF, 16'h0000, 16'h8001, 16'h2000};

   task automatic test_directed();
      obs_t o;
      for (int i = 0; i < 8; i++) begin
         run_req(d_ph[i], d_val[i], d_n[i], 1'b0, -1, 16'h0000, -1, o);
         @(negedge clk);
         n_cmp++; if (o.angle_l !== d_ang[i]) begin n_bad++; $display("FAIL dir_angle[%0d] got %h want %h", i, o.angle_l, d_ang[i]); end
         n_cmp++; if (o.angle_w !== d_ang[i]) begin n_bad++; $display("FAIL dir_angle_hold[%0d] got %h want %h", i, o.angle_w, d_ang[i]); end
         n_cmp++; if (o.sine !== d_sin[i]) begin n_bad++; $display("FAIL dir_sine[%0d] got %h want %h", i, o.sine, d_sin[i]); end
         n_cmp++; if (o.done_cyc !== 3 + d_n[i] || o.done_cnt !== 1) begin n_bad++; $display("FAIL dir_done[%0d] got cyc %0d cnt %0d want cyc %0d cnt 1", i, o.done_cyc, o.done_cnt, 3 + d_n[i]); end
         n_cmp++; if (o.start_cyc !== 2 || o.start_cnt !== 1) begin n_bad++; $display("FAIL dir_cstart[%0d] got cyc %0d cnt %0d want cyc 2 cnt 1", i, o.start_cyc, o.start_cnt); end
         n_cmp++; if (o.busy_bad !== 0) begin n_bad++; $display("FAIL dir_busy[%0d] got %0d bad cycles want 0", i, o.busy_bad); end
         n_cmp++; if (o.err !== 1'b0) begin n_bad++; $display("FAIL dir_err[%0d] got %b want 0", i, o.err); end
      end
   endtask

   task automatic test_random();
      obs_t o;
      logic [15:0] ph, v;
      int n;
      for (int i = 0; i < 24; i++) begin
         ph = 16'($urandom);
         v  = 16'($urandom);
         n  = int'($urandom_range(1, 6));
         run_req(ph, v, n, 1'b0, -1, 16'h0000, -1, o);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         n_cmp++; if (o.angle_l !== ref_angle(ph)) begin n_bad++; $display("FAIL rnd_angle ph %h got %h want %h", ph, o.angle_l, ref_angle(ph)); end
         n_cmp++; if (o.sine !== ref_sine(ph, v)) begin n_bad++; $display("FAIL rnd_sine ph %h v %h got %h want %h", ph, v, o.sine, ref_sine(ph, v)); end
         n_cmp++; if (o.done_cyc !== 3 + n || o.done_cnt !== 1) begin n_bad++; $display("FAIL rnd_done got cyc %0d cnt %0d want cyc %0d cnt 1", o.done_cyc, o.done_cnt, 3 + n); end
         n_cmp++; if (o.busy_bad !== 0 || o.start_cnt !== 1) begin n_bad++; $display("FAIL rnd_busy got bad %0d starts %0d want 0 and 1", o.busy_bad, o.start_cnt); end
      end
   endtask

   task automatic test_back_to_back();
      obs_t o;
      logic [15:0] ph [3] = '{16'h1555, 16'hEAAB, 16'h4000};
      for (int i = 0; i < 3; i++) begin
         run_req(ph[i], 16'h2468, 2, 1'b0, -1, 16'h0000, -1, o);
         n_cmp++; if (o.done_cyc !== 5 || o.sine !== ref_sine(ph[i], 16'h2468) || o.angle_l !== ref_angle(ph[i])) begin
            n_bad++; $display("FAIL b2b[%0d] got cyc %0d sine %h angle %h want cyc 5 sine %h angle %h", i, o.done_cyc, o.sine, o.angle_l, ref_sine(ph[i], 16'h2468), ref_angle(ph[i]));
         end
      end
      @(negedge clk);
   endtask

   task automatic test_busy_ignore();
      obs_t o;
      run_req(16'h1555, 16'h4000, 5, 1'b0, 4, 16'hC000, 2, o);
      n_cmp++; if (o.done_cnt !== 1 || o.done_cyc !== 8) begin n_bad++; $display("FAIL ign_wait_done got cnt %0d cyc %0d want 1 and 8", o.done_cnt, o.done_cyc); end
      n_cmp++; if (o.sine !== 16'h4000) begin n_bad++; $display("FAIL ign_wait_sine got %h want 4000", o.sine); end
      n_cmp++; if (o.angle_w !== 16'h2182) begin n_bad++; $display("FAIL ign_wait_angle got %h want 2182", o.angle_w); end
      n_cmp++; if (o.busy_bad !== 0 || o.start_cnt !== 1) begin n_bad++; $display("FAIL ign_wait_busy got bad %0d starts %0d want 0 and 1", o.busy_bad, o.start_cnt); end
      run_req(16'hEAAB, 16'h3000, 3, 1'b0, 6, 16'h4000, -1, o);
      n_cmp++; if (o.sine !== 16'hD000 || o.done_cnt !== 1) begin n_bad++; $display("FAIL ign_fix_sine got %h cnt %0d want D000 cnt 1", o.sine, o.done_cnt); end
      n_cmp++; if (o.busy_bad !== 0) begin n_bad++; $display("FAIL ign_fix_busy got %0d bad cycles want 0", o.busy_bad); end
      stray = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_cmp++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL ign_idle_done got done %b busy %b want 0 0", bus.done, bus.busy); end
      end
      stray = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int bad;
      core_val  = 16'h1111;
      core_lat  = 8;
      core_mute = 1'b0;
      bus.start = 1'b1;
      bus.phase = 16'h1555;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.core_start !== 1'b0) begin n_bad++; $display("FAIL rstmid_ctrl got busy %b done %b cstart %b want 0 0 0", bus.busy, bus.done, bus.core_start); end
      n_cmp++; if (bus.sine !== 16'h0000 || bus.core_angle !== 16'h0000 || bus.err !== 1'b0) begin n_bad++; $display("FAIL rstmid_data got sine %h angle %h err %b want 0", bus.sine, bus.core_angle, bus.err); end
      rst_n = 1'b1;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.sine !== 16'h0000) bad++;
      end
      n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL rstmid_no_done got %0d bad cycles want 0", bad); end
   endtask

`ifdef QFOLD_TIMEOUT_EN
   task automatic test_timeout();
      obs_t o;
      run_req(16'h1555, 16'h1111, TIMEOUT, 1'b1, -1, 16'h0000, -1, o);
      n_cmp++; if (o.done_cyc !== 3 + TIMEOUT || o.done_cnt !== 1) begin n_bad++; $display("FAIL tmo_done got cyc %0d cnt %0d want %0d 1", o.done_cyc, o.done_cnt, 3 + TIMEOUT); end
      n_cmp++; if (o.err !== 1'b1 || o.sine !== 16'h0000) begin n_bad++; $display("FAIL tmo_err got err %b sine %h want 1 0000", o.err, o.sine); end
      run_req(16'h1555, 16'h4000, 2, 1'b0, -1, 16'h0000, -1, o);
      n_cmp++; if (o.err !== 1'b0 || o.sine !== 16'h4000) begin n_bad++; $display("FAIL tmo_clear got err %b sine %h want 0 4000", o.err, o.sine); end
      @(negedge clk);
   endtask
`endif

   initial begin
      bus.start = 1'b0;
      bus.phase = 16'h0000;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_busy_ignore();
      test_reset_mid();
`ifdef QFOLD_TIMEOUT_EN
      test_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
